// File: rtl/pulse_id_pkg.sv
// Shared types and timing defaults for the multi-sensor pulse identifier.
package pulse_id_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SETTLE,
    POLY,
    OFFSET,
    DONE,
    DRAIN,
    CLEAR
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_POLY    = 2'd1;
  localparam logic [1:0] ERR_OFFSET  = 2'd2;

  localparam int TIMEOUT_TICKS_DEF = 50000;
  localparam int SETTLE_TICKS_DEF  = 5000;
  localparam int ITER_SHIFT_DEF    = 4;

endpackage

// File: rtl/arrival_tracker.sv
// Latches first-arrival timestamps per sensor and ranks the first two
// arrivals, lowest index first among simultaneous arrivals.
module arrival_tracker #(
  parameter int N_SENSORS = 4,
  parameter int TS_W      = 24,
  parameter int SEL_W     = 2
) (
  input  logic                      clk_96MHz,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic [TS_W-1:0]           sys_ts,
  input  logic [N_SENSORS-1:0]      avl_nonempty,
  output logic [N_SENSORS-1:0]      seen,
  output logic [N_SENSORS*TS_W-1:0] ts_arr,
  output logic [SEL_W-1:0]          sel_a,
  output logic [SEL_W-1:0]          sel_b,
  output logic                      any_new,
  output logic                      pair
);

  logic [N_SENSORS-1:0] fresh;
  logic [1:0]           cnt;
  logic [1:0]           cnt_n;
  logic [SEL_W-1:0]     sel_a_n;
  logic [SEL_W-1:0]     sel_b_n;

  always_comb begin
    fresh   = avl_nonempty & ~seen & {N_SENSORS{en}};
    cnt_n   = cnt;
    sel_a_n = sel_a;
    sel_b_n = sel_b;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (fresh[i]) begin
        if (cnt_n == 2'd0) begin
          sel_a_n = SEL_W'(i);
          cnt_n   = 2'd1;
        end else if (cnt_n == 2'd1) begin
          sel_b_n = SEL_W'(i);
          cnt_n   = 2'd2;
        end
      end
    end
  end

  assign any_new = |fresh;
  assign pair    = (cnt == 2'd2);

  always_ff @(posedge clk_96MHz) begin
    if (reset || clear) begin
      seen   <= '0;
      ts_arr <= '0;
      cnt    <= '0;
      sel_a  <= '0;
      sel_b  <= '0;
    end else begin
      seen  <= seen | fresh;
      cnt   <= cnt_n;
      sel_a <= sel_a_n;
      sel_b <= sel_b_n;
      for (int i = 0; i < N_SENSORS; i++) begin
        if (fresh[i]) ts_arr[i*TS_W +: TS_W] <= sys_ts;
      end
    end
  end

endmodule

// File: rtl/multi_sensor_pulse_identifier.sv
// Assigns LFSR pulse ids to photodiode arrivals of one sweep.
// Define PULSE_ID_ERR_STATS_EN to add err_count/err_cause failure stats.
module multi_sensor_pulse_identifier
  import pulse_id_pkg::*;
#(
  parameter int N_SENSORS     = 4,
  parameter int TS_W          = 24,
  parameter int ID_W          = 17,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int SETTLE_TICKS  = SETTLE_TICKS_DEF,
  parameter int ITER_SHIFT    = ITER_SHIFT_DEF,
  localparam int SEL_W        = $clog2(N_SENSORS)
) (
  input  logic                      clk_96MHz,
  input  logic                      reset,
  input  logic [TS_W-1:0]           sys_ts,
  input  logic [N_SENSORS-1:0]      avl_nonempty,
  output logic                      poly_start,
  output logic [SEL_W-1:0]          poly_sel_a,
  output logic [SEL_W-1:0]          poly_sel_b,
  input  logic                      poly_done,
  input  logic                      poly_ok,
  input  logic [ID_W-1:0]           poly_iter,
  input  logic [TS_W-1:0]           poly_ts_first,
  output logic                      offset_start,
  input  logic                      offset_done,
  input  logic [ID_W-1:0]           offset_value,
  output logic [N_SENSORS*ID_W-1:0] pulse_id,
  output logic [N_SENSORS-1:0]      id_valid,
  output logic                      ready,
  input  logic                      ack
`ifdef PULSE_ID_ERR_STATS_EN
  ,
  output logic [7:0]                err_count,
  output logic [1:0]                err_cause
`endif
);

  localparam int WIN_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int SET_W = $clog2(SETTLE_TICKS + 1);

  state_t                    state;
  state_t                    state_n;
  logic [WIN_W-1:0]          win;
  logic [SET_W-1:0]          settle;
  logic [N_SENSORS-1:0]      seen;
  logic [N_SENSORS*TS_W-1:0] ts_arr;
  logic [SEL_W-1:0]          sel_a;
  logic [SEL_W-1:0]          sel_b;
  logic                      any_new;
  logic                      pair;
  logic                      active;
  logic                      timeout;
  logic [ID_W-1:0]           iter_q;
  logic [TS_W-1:0]           first_q;
  logic [N_SENSORS*ID_W-1:0] ids;
  logic [TS_W-1:0]           dk;

  assign active  = (state == COLLECT) || (state == SETTLE) ||
                   (state == POLY)    || (state == OFFSET);
  assign timeout = active && (win == WIN_W'(TIMEOUT_TICKS));

  arrival_tracker #(
    .N_SENSORS (N_SENSORS),
    .TS_W      (TS_W),
    .SEL_W     (SEL_W)
  ) u_tracker (
    .clk_96MHz    (clk_96MHz),
    .reset        (reset),
    .clear        (state == CLEAR),
    .en           (active || (state == IDLE)),
    .sys_ts       (sys_ts),
    .avl_nonempty (avl_nonempty),
    .seen         (seen),
    .ts_arr       (ts_arr),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .any_new      (any_new),
    .pair         (pair)
  );

  assign poly_sel_a = sel_a;
  assign poly_sel_b = sel_b;
  assign ready      = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_new) state_n = COLLECT;
      COLLECT: if (pair) state_n = SETTLE;
      SETTLE:  if (settle == SET_W'(SETTLE_TICKS - 1)) state_n = POLY;
      POLY:    if (poly_done) state_n = poly_ok ? OFFSET : CLEAR;
      OFFSET:  if (offset_done)
                 state_n = (offset_value == '0) ? CLEAR : DONE;
      DONE:    if (ack) state_n = DRAIN;
      DRAIN:   if (avl_nonempty == '0) state_n = CLEAR;
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = CLEAR;
  end

  // Later arrivals are timed relative to the first sensor's edge.
  always_comb begin
    ids = '0;
    dk  = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      dk = ts_arr[k*TS_W +: TS_W] - first_q;
      if (seen[k]) begin
        if (SEL_W'(k) == sel_a)
          ids[k*ID_W +: ID_W] = offset_value;
        else if (SEL_W'(k) == sel_b)
          ids[k*ID_W +: ID_W] = offset_value + iter_q;
        else
          ids[k*ID_W +: ID_W] = offset_value + ID_W'(dk >> ITER_SHIFT);
      end
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state        <= IDLE;
      win          <= '0;
      settle       <= '0;
      iter_q       <= '0;
      first_q      <= '0;
      poly_start   <= 1'b0;
      offset_start <= 1'b0;
      pulse_id     <= '0;
      id_valid     <= '0;
    end else begin
      state        <= state_n;
      poly_start   <= (state_n == POLY) && (state != POLY);
      offset_start <= (state_n == OFFSET) && (state != OFFSET);
      if ((state == IDLE) && (state_n == COLLECT)) win <= WIN_W'(1);
      else if (!active) win <= '0;
      else if (!timeout) win <= win + 1'b1;
      settle <= (state == SETTLE) ? settle + 1'b1 : '0;
      if ((state == POLY) && (state_n == OFFSET)) begin
        iter_q  <= poly_iter;
        first_q <= poly_ts_first;
      end
      if ((state == OFFSET) && (state_n == DONE)) begin
        pulse_id <= ids;
        id_valid <= seen;
      end else if (state == CLEAR) begin
        pulse_id <= '0;
        id_valid <= '0;
      end
    end
  end

`ifdef PULSE_ID_ERR_STATS_EN
  logic       fail;
  logic [1:0] cause;

  // Any active state falling into CLEAR is a failure.
  always_comb begin
    fail  = active && (state_n == CLEAR);
    cause = ERR_OFFSET;
    if (timeout) cause = ERR_TIMEOUT;
    else if (state == POLY) cause = ERR_POLY;
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      err_count <= '0;
      err_cause <= ERR_TIMEOUT;
    end else if (fail) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      err_cause <= cause;
    end
  end
`endif

endmodule
